// File: rtl/inst_cache_pkg.sv
// Shared widths, FSM state encoding and line helpers for the instruction cache.
package inst_cache_pkg;

   localparam int WORD_SIZE      = 16;
   localparam int LINE_SIZE      = 64;
   localparam int WORDS_PER_LINE = 4;
   localparam int OFFSET_BITS    = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   // Word k of a line sits at bits [16k+15:16k].
   function automatic logic [WORD_SIZE-1:0] line_word(input logic [LINE_SIZE-1:0] line,
                                                      input logic [OFFSET_BITS-1:0] off);
      return line[off*WORD_SIZE +: WORD_SIZE];
   endfunction

   // Clear the word offset to get the line-aligned address.
   function automatic logic [WORD_SIZE-1:0] line_base(input logic [WORD_SIZE-1:0] addr);
      return {addr[WORD_SIZE-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
   endfunction

endpackage

// File: rtl/inst_cache_if.sv
// Fetch-side and line-memory-side signals of the instruction cache.
// slave: the cache itself; master: the CPU fetch unit plus instruction memory.
interface inst_cache_if;
   import inst_cache_pkg::*;

   logic                 cpu_read;
   logic [WORD_SIZE-1:0] cpu_address;
   logic [WORD_SIZE-1:0] cpu_data;
   logic                 cpu_ready;

   logic                 i_readM;
   logic [WORD_SIZE-1:0] i_address;
   logic [LINE_SIZE-1:0] i_data;
   logic                 i_valid;

   modport slave (
      input  cpu_read, cpu_address, i_data, i_valid,
      output cpu_data, cpu_ready, i_readM, i_address
   );

   modport master (
      output cpu_read, cpu_address, i_data, i_valid,
      input  cpu_data, cpu_ready, i_readM, i_address
   );

endinterface

// File: rtl/inst_cache_line_array.sv
// Valid/tag/data storage for the direct-mapped cache: one write port,
// one combinational read port. Only the valid bits are reset.
module cache_line_array
   import inst_cache_pkg::*;
#(
   parameter  int NUM_LINES = 4,
   localparam int IDX_W     = $clog2(NUM_LINES),
   localparam int TAG_W     = WORD_SIZE - OFFSET_BITS - IDX_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_wr_en,
   input  logic [IDX_W-1:0]     i_wr_idx,
   input  logic [TAG_W-1:0]     i_wr_tag,
   input  logic [LINE_SIZE-1:0] i_wr_data,
   input  logic [IDX_W-1:0]     i_rd_idx,
   output logic                 o_rd_valid,
   output logic [TAG_W-1:0]     o_rd_tag,
   output logic [LINE_SIZE-1:0] o_rd_data
);

   logic [NUM_LINES-1:0] r_valid;
   logic [TAG_W-1:0]     r_tag  [NUM_LINES];
   logic [LINE_SIZE-1:0] r_data [NUM_LINES];

   // Valid bits: cleared by reset, set by a fill.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= '0;
      end else if (i_wr_en) begin
         r_valid[i_wr_idx] <= 1'b1;
      end
   end

   // Tag and data: written on fill only, contents meaningless until valid.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_tag[i_wr_idx]  <= i_wr_tag;
         r_data[i_wr_idx] <= i_wr_data;
      end
   end

   assign o_rd_valid = r_valid[i_rd_idx];
   assign o_rd_tag   = r_tag[i_rd_idx];
   assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache. Hits answer combinationally in
// the request cycle; a miss fetches one 64-bit line and the CPU re-presents.
// Optional hit/miss counters are built when INST_CACHE_STATS_EN is defined.
//
// state | meaning
// IDLE  | serve hits, launch a line fill on a miss
// FILL  | i_readM held high on the latched line address until i_valid
// WAIT  | one quiet cycle after the array write, then back to IDLE
module inst_cache
   import inst_cache_pkg::*;
#(
   parameter int NUM_LINES = 4
) (
   input  logic              clk,
   input  logic              reset,
   inst_cache_if.slave       bus
`ifdef INST_CACHE_STATS_EN
   ,
   output logic [15:0]       hit_count,
   output logic [15:0]       miss_count
`endif
);

   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = WORD_SIZE - OFFSET_BITS - IDX_W;

   state_t               r_state;
   logic [WORD_SIZE-1:0] r_line_addr;
   logic                 r_readM;

   logic [OFFSET_BITS-1:0] w_off;
   logic [IDX_W-1:0]       w_idx;
   logic [TAG_W-1:0]       w_tag;
   logic                   w_rd_valid;
   logic [TAG_W-1:0]       w_rd_tag;
   logic [LINE_SIZE-1:0]   w_rd_data;
   logic                   w_hit;
   logic                   w_wr_en;

   assign w_off = bus.cpu_address[OFFSET_BITS-1:0];
   assign w_idx = bus.cpu_address[OFFSET_BITS +: IDX_W];
   assign w_tag = bus.cpu_address[WORD_SIZE-1 -: TAG_W];

   // A late i_valid outside FILL, or in the reset cycle, must not touch the array.
   assign w_wr_en = (r_state == ST_FILL) && bus.i_valid && !reset;

   cache_line_array #(.NUM_LINES(NUM_LINES)) u_lines (
      .clk        (clk),
      .reset      (reset),
      .i_wr_en    (w_wr_en),
      .i_wr_idx   (r_line_addr[OFFSET_BITS +: IDX_W]),
      .i_wr_tag   (r_line_addr[WORD_SIZE-1 -: TAG_W]),
      .i_wr_data  (bus.i_data),
      .i_rd_idx   (w_idx),
      .o_rd_valid (w_rd_valid),
      .o_rd_tag   (w_rd_tag),
      .o_rd_data  (w_rd_data)
   );

   assign w_hit = bus.cpu_read && w_rd_valid && (w_rd_tag == w_tag) && (r_state == ST_IDLE);

   assign bus.cpu_ready = w_hit;
   assign bus.cpu_data  = w_hit ? line_word(w_rd_data, w_off) : '0;
   assign bus.i_readM   = r_readM;
   assign bus.i_address = r_line_addr;

   // Miss sequencing; the latched line address doubles as the registered i_address.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_readM     <= 1'b0;
         r_line_addr <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.cpu_read && !w_hit) begin
                  r_line_addr <= line_base(bus.cpu_address);
                  r_readM     <= 1'b1;
                  r_state     <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (bus.i_valid) begin
                  r_readM <= 1'b0;
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_readM <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef INST_CACHE_STATS_EN
   // Free-running wrap-around hit and miss counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (w_hit) begin
            hit_count <= hit_count + 16'd1;
         end
         if ((r_state == ST_IDLE) && bus.cpu_read && !w_hit) begin
            miss_count <= miss_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Randomized and directed bench for inst_cache against a line-level cache model.
module tb_inst_cache;
   import inst_cache_pkg::*;

   localparam int NL = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   inst_cache_if bus();

`ifdef INST_CACHE_STATS_EN
   logic [15:0] hit_count;
   logic [15:0] miss_count;
`endif

   inst_cache #(.NUM_LINES(NL)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus)
`ifdef INST_CACHE_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: cache contents per line, plus whether a fill is in flight.
   bit          m_valid [NL];
   int unsigned m_tag   [NL];
   logic [63:0] m_line  [NL];
   int          m_phase;      // 0 serving, 1 waiting for memory, 2 recovery cycle
   logic [15:0] m_fill_addr;
   logic        m_readM;
   logic [15:0] m_hits;
   logic [15:0] m_misses;

   logic        o_ready;
   logic [15:0] o_data;
   logic        o_readM;
   logic [15:0] o_iaddr;
   logic [15:0] o_hits;
   logic [15:0] o_misses;

   function automatic int unsigned idx_of(input logic [15:0] a);
      return (int'(a) / 4) % NL;
   endfunction

   function automatic int unsigned tag_of(input logic [15:0] a);
      return int'(a) / (4 * NL);
   endfunction

   function automatic logic [15:0] word_of(input logic [63:0] line, input logic [15:0] a);
      logic [63:0] t;
      t = line >> (16 * (int'(a) % 4));
      return t[15:0];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
      m_phase     = 0;
      m_readM     = 1'b0;
      m_fill_addr = 16'h0;
      m_hits      = 16'h0;
      m_misses    = 16'h0;
   endtask

   // One clock: drive at negedge, check mid-low-phase, then advance the model.
   task automatic cycle(input logic rd, input logic [15:0] a, input logic v,
                        input logic [63:0] d, input logic rs);
      bit          e_ready;
      logic [15:0] e_data;
      int unsigned li;
      @(negedge clk);
      bus.cpu_read    = rd;
      bus.cpu_address = a;
      bus.i_valid     = v;
      bus.i_data      = d;
      reset           = rs;
      #1;
      li      = idx_of(a);
      e_ready = (m_phase == 0) && rd && m_valid[li] && (m_tag[li] == tag_of(a));
      e_data  = e_ready ? word_of(m_line[li], a) : 16'h0;
      o_ready = bus.cpu_ready;
      o_data  = bus.cpu_data;
      o_readM = bus.i_readM;
      o_iaddr = bus.i_address;
      chk("cpu_ready", {63'b0, o_ready}, {63'b0, e_ready});
      chk("cpu_data", {48'b0, o_data}, {48'b0, e_data});
      chk("i_readM", {63'b0, o_readM}, {63'b0, m_readM});
      chk("i_address", {48'b0, o_iaddr}, {48'b0, m_fill_addr});
`ifdef INST_CACHE_STATS_EN
      o_hits   = hit_count;
      o_misses = miss_count;
      chk("hit_count", {48'b0, o_hits}, {48'b0, m_hits});
      chk("miss_count", {48'b0, o_misses}, {48'b0, m_misses});
`else
      o_hits   = 16'h0;
      o_misses = 16'h0;
`endif
      if (rs) begin
         model_reset();
      end else begin
         if (e_ready) m_hits++;
         case (m_phase)
            0: if (rd && !e_ready) begin
                  m_fill_addr = a - 16'(int'(a) % 4);
                  m_readM     = 1'b1;
                  m_phase     = 1;
                  m_misses++;
               end
            1: if (v) begin
                  m_valid[idx_of(m_fill_addr)] = 1'b1;
                  m_tag[idx_of(m_fill_addr)]   = tag_of(m_fill_addr);
                  m_line[idx_of(m_fill_addr)]  = d;
                  m_readM = 1'b0;
                  m_phase = 2;
               end
            default: m_phase = 0;
         endcase
      end
   endtask

   // Miss on a, memory answers L cycles into FILL, wait (bounded) for the hit.
   task automatic miss_fill(input logic [15:0] a, input int lat_mem, input logic [63:0] d);
      int lat;
      cycle(1'b1, a, 1'b0, 64'h0, 1'b0);
      chk("miss_not_ready", {63'b0, o_ready}, 64'h0);
      for (int n = 0; n <= lat_mem; n++) begin
         cycle(1'b1, a, (n == lat_mem), d, 1'b0);
         if (n == 0) chk("fill_addr", {48'b0, o_iaddr}, {48'b0, a & 16'hFFFC});
      end
      lat = 1 + lat_mem;
      for (int j = 0; j < 8; j++) begin
         cycle(1'b1, a, 1'b0, 64'h0, 1'b0);
         lat++;
         if (o_ready) break;
      end
      chk("miss_latency", lat, 3 + lat_mem);
   endtask

   // From FILL with the request held: deliver a line, then the hit.
   task automatic complete(input logic [15:0] a);
      cycle(1'b1, a, 1'b1, {$urandom, $urandom}, 1'b0);
      cycle(1'b1, a, 1'b0, 64'h0, 1'b0);
      cycle(1'b1, a, 1'b0, 64'h0, 1'b0);
      chk("complete_hit", {63'b0, o_ready}, 64'h1);
   endtask

   initial begin
      logic [63:0] d1;
      bus.cpu_read    = 1'b0;
      bus.cpu_address = 16'h0;
      bus.i_valid     = 1'b0;
      bus.i_data      = 64'h0;
      reset           = 1'b1;
      repeat (2) @(posedge clk);
      model_reset();
      cycle(1'b0, 16'h0, 1'b0, 64'h0, 1'b1);

      // Reset state
      cycle(1'b0, 16'h0005, 1'b0, 64'h0, 1'b0);
      chk("rst_readM", {63'b0, o_readM}, 64'h0);
      chk("rst_iaddr", {48'b0, o_iaddr}, 64'h0);

      // Cold miss, then same-line hits
      miss_fill(16'h0005, 1, 64'h4444_3333_2222_1111);
      chk("cold_data", {48'b0, o_data}, 64'h2222);
      cycle(1'b1, 16'h0004, 1'b0, 64'h0, 1'b0);
      chk("hit_0004", {48'b0, o_data}, 64'h1111);
      cycle(1'b1, 16'h0006, 1'b0, 64'h0, 1'b0);
      chk("hit_0006", {48'b0, o_data}, 64'h3333);
      cycle(1'b1, 16'h0007, 1'b0, 64'h0, 1'b0);
      chk("hit_0007", {48'b0, o_data}, 64'h4444);

      // Conflict eviction on index 0
      miss_fill(16'h0000, 3, {$urandom, $urandom});
      miss_fill(16'h0010, 0, {$urandom, $urandom});
      cycle(1'b1, 16'h0000, 1'b0, 64'h0, 1'b0);
      chk("evicted_miss", {63'b0, o_ready}, 64'h0);
      complete(16'h0000);

      // Reset while a fill is outstanding
      cycle(1'b1, 16'h0040, 1'b0, 64'h0, 1'b0);
      cycle(1'b1, 16'h0040, 1'b0, 64'h0, 1'b0);
      chk("midfill_readM", {63'b0, o_readM}, 64'h1);
      cycle(1'b0, 16'h0040, 1'b0, 64'h0, 1'b1);
      cycle(1'b0, 16'h0040, 1'b0, 64'h0, 1'b0);
      chk("post_rst_readM", {63'b0, o_readM}, 64'h0);
      cycle(1'b0, 16'h0040, 1'b1, 64'hDEAD_BEEF_0000_1234, 1'b0);
      cycle(1'b1, 16'h0040, 1'b0, 64'h0, 1'b0);
      chk("post_rst_miss", {63'b0, o_ready}, 64'h0);
      complete(16'h0040);

      // Address moves during FILL
      d1 = {$urandom, $urandom};
      cycle(1'b1, 16'h0020, 1'b0, 64'h0, 1'b0);
      cycle(1'b1, 16'h0031, 1'b0, 64'h0, 1'b0);
      chk("move_iaddr", {48'b0, o_iaddr}, 64'h0020);
      cycle(1'b1, 16'h0031, 1'b1, d1, 1'b0);
      cycle(1'b1, 16'h0031, 1'b0, 64'h0, 1'b0);
      cycle(1'b1, 16'h0020, 1'b0, 64'h0, 1'b0);
      chk("move_hit20", {48'b0, o_data}, {48'b0, d1[15:0]});
      cycle(1'b1, 16'h0031, 1'b0, 64'h0, 1'b0);
      chk("move_miss31", {63'b0, o_ready}, 64'h0);
      cycle(1'b1, 16'h0031, 1'b0, 64'h0, 1'b0);
      chk("move_iaddr30", {48'b0, o_iaddr}, 64'h0030);
      complete(16'h0031);

      // Spurious i_valid while idle
      cycle(1'b0, 16'h0080, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0);
      cycle(1'b1, 16'h0080, 1'b0, 64'h0, 1'b0);
      chk("spurious_miss", {63'b0, o_ready}, 64'h0);
      complete(16'h0080);

`ifdef INST_CACHE_STATS_EN
      cycle(1'b0, 16'h0, 1'b0, 64'h0, 1'b1);
      miss_fill(16'h0100, 1, {$urandom, $urandom});
      cycle(1'b1, 16'h0101, 1'b0, 64'h0, 1'b0);
      cycle(1'b1, 16'h0102, 1'b0, 64'h0, 1'b0);
      cycle(1'b0, 16'h0, 1'b0, 64'h0, 1'b0);
      chk("stats_hits", {48'b0, o_hits}, 64'd3);
      chk("stats_misses", {48'b0, o_misses}, 64'd1);
      cycle(1'b0, 16'h0, 1'b0, 64'h0, 1'b1);
      cycle(1'b0, 16'h0, 1'b0, 64'h0, 1'b0);
      chk("stats_rst_hits", {48'b0, o_hits}, 64'd0);
      chk("stats_rst_misses", {48'b0, o_misses}, 64'd0);
`endif

      // Random traffic, mostly within a small address window so lines get reused
      for (int k = 0; k < 3000; k++) begin
         logic        rs;
         logic        rd;
         logic [15:0] a;
         rs = ($urandom_range(0, 199) == 0);
         rd = rs ? 1'b0 : ($urandom_range(0, 3) != 0);
         a  = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63));
         cycle(rd, a, ($urandom_range(0, 2) == 0), {$urandom, $urandom}, rs);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
